msrv32_pipe_ctrl: RTL and testbench
===================================

MSRV32_PIPE_CTRL -- requirements
Module: msrv32_pipe_ctrl

Interface
REQ-001 Parameter INIT_CYCLES, default 2: post-reset flush cycles (range 1..15).
REQ-002 Parameter MEM_TIMEOUT, default 16: data-memory wait limit in MEM_WAIT cycles (range 2..255).
REQ-003 Parameter CNT_W, default 16: performance counter width.
REQ-004 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_in  input  1  synchronous, active-high reset.
REQ-006 branch_taken_in  input  1  stage-3 branch/jump redirect.
REQ-007 trap_taken_in  input  1  trap/interrupt redirect.
REQ-008 ex_load_in  input  1  stage-3 instruction is a load.
REQ-009 ex_rd_addr_in  input  5  stage-3 destination register.
REQ-010 id_rs1_addr_in, id_rs2_addr_in  input  5 each  stage-2 source registers.
REQ-011 id_rs1_used_in, id_rs2_used_in  input  1 each  source operand is actually read.
REQ-012 dmem_req_in  input  1  stage 3 is issuing a data-memory access.
REQ-013 dmem_ack_in  input  1  data memory completes the access this cycle.
REQ-014 pc_en_out  output  1  PC register load enable.
REQ-015 rb1_en_out, rb1_flush_out  output  1 each  stage-1/2 pipeline register enable and bubble insert.
REQ-016 rb2_en_out, rb2_flush_out  output  1 each  stage-2/3 pipeline register enable and bubble insert.
REQ-017 bus_err_out  output  1  one-cycle pulse on memory timeout.
REQ-018 state_out  output  2  INIT=0, RUN=1, MEM_WAIT=2.
REQ-019 stall_cnt_out, flush_cnt_out  output  CNT_W each  saturating performance counters.

Function
REQ-020 The block SHALL implement a three-state FSM (INIT, RUN, MEM_WAIT); enable, flush, and bus_err outputs SHALL be combinational from current state and inputs.
REQ-021 Whenever an rbX_flush_out is 1, the matching rbX_en_out SHALL also be 1, so the register loads a bubble (zero control fields).
REQ-022 INIT: outputs pc_en=0, rb1_en=rb1_flush=1, rb2_en=rb2_flush=1; all inputs ignored; after exactly INIT_CYCLES cycles in INIT, next state is RUN.
REQ-023 RUN, default: pc_en=rb1_en=rb2_en=1, both flushes 0.
REQ-024 RUN priority 1, memory wait (dmem_req_in=1 and dmem_ack_in=0): pc_en=rb1_en=rb2_en=0, no flushes; next MEM_WAIT with wait_cnt cleared to 0.
REQ-025 RUN priority 2, redirect (branch_taken_in or trap_taken_in): pc_en=1, rb1_flush=rb2_flush=1; stay RUN.
REQ-026 RUN priority 3, load-use hazard (ex_load_in=1, ex_rd_addr_in!=0, and (rs1_used and rs1==rd) or (rs2_used and rs2==rd)): pc_en=0, rb1_en=0, rb2_flush=1; stay RUN.
REQ-027 A redirect SHALL suppress a simultaneous load-use stall; a memory wait SHALL suppress both, since the frozen redirect is re-presented after the wait.
REQ-028 MEM_WAIT, dmem_ack_in=1: pc_en=rb1_en=rb2_en=1; next RUN; ack wins over a coincident timeout.
REQ-029 MEM_WAIT, dmem_ack_in=0 and wait_cnt<MEM_TIMEOUT-1: all enables 0; wait_cnt increments.
REQ-030 MEM_WAIT, dmem_ack_in=0 and wait_cnt==MEM_TIMEOUT-1: bus_err_out=1, pc_en=0, rb1_en=0, rb2_flush=1 (kills the faulting access); next RUN.
REQ-031 stall_cnt SHALL increment for each RUN or MEM_WAIT cycle with pc_en_out=0, and saturate at all-ones.
REQ-032 flush_cnt SHALL increment for each RUN cycle taking a redirect (REQ-025), and saturate at all-ones.
REQ-033 INIT cycles SHALL NOT count in either counter.

Reset
REQ-034 On any rising edge with reset_in=1, the block SHALL set state=INIT, init_cnt=0, wait_cnt=0, stall_cnt=0, flush_cnt=0, regardless of current state, including mid-MEM_WAIT.
REQ-035 While reset_in is held, outputs SHALL show INIT values from the first reset edge onward; the INIT_CYCLES count starts on the first edge with reset_in=0.

Verification
REQ-036 Reset held 3 cycles then released (INIT_CYCLES=2) -> 2 cycles with pc_en=0 and both flushes 1, then state_out=1 with all enables 1 and counters 0.
REQ-037 RUN with ex_load=1, rd=5, rs1=5, rs1_used=1 -> one cycle pc_en=0, rb1_en=0, rb2_flush=1, stall_cnt 0->1; same stimulus with rd=0 -> no stall.
REQ-038 Branch_taken=1 together with the REQ-037 hazard -> pc_en=1, rb1_flush=rb2_flush=1, flush_cnt +1, stall_cnt unchanged.
REQ-039 req=1/ack=0 from cycle t, ack at t+3 -> enables 0 at t..t+2, enables 1 at t+3, RUN at t+4, stall_cnt +3, no bus_err.
REQ-040 MEM_TIMEOUT=4, req=1, ack never -> bus_err_out=1 only at t+4 with rb2_flush=1; RUN at t+5; stall_cnt +5.
REQ-041 reset_in=1 during MEM_WAIT, and stall_cnt at all-ones before reset -> state_out=0 next cycle and both counters 0.

Source files
------------

// File: rtl/msrv32_pipe_ctrl_if.sv
// Pipeline-control bundle between the datapath (master) and the hazard/stall controller (slave).
// Carries hazard/redirect/memory inputs and the enable/flush/status outputs.
interface msrv32_pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             branch_taken_in;
  logic             trap_taken_in;
  logic             ex_load_in;
  logic [4:0]       ex_rd_addr_in;
  logic [4:0]       id_rs1_addr_in;
  logic [4:0]       id_rs2_addr_in;
  logic             id_rs1_used_in;
  logic             id_rs2_used_in;
  logic             dmem_req_in;
  logic             dmem_ack_in;

  logic             pc_en_out;
  logic             rb1_en_out;
  logic             rb1_flush_out;
  logic             rb2_en_out;
  logic             rb2_flush_out;
  logic             bus_err_out;
  logic [1:0]       state_out;
  logic [CNT_W-1:0] stall_cnt_out;
  logic [CNT_W-1:0] flush_cnt_out;

  modport slave (
    input  branch_taken_in, trap_taken_in, ex_load_in, ex_rd_addr_in,
           id_rs1_addr_in, id_rs2_addr_in, id_rs1_used_in, id_rs2_used_in,
           dmem_req_in, dmem_ack_in,
    output pc_en_out, rb1_en_out, rb1_flush_out, rb2_en_out, rb2_flush_out,
           bus_err_out, state_out, stall_cnt_out, flush_cnt_out
  );

  modport master (
    output branch_taken_in, trap_taken_in, ex_load_in, ex_rd_addr_in,
           id_rs1_addr_in, id_rs2_addr_in, id_rs1_used_in, id_rs2_used_in,
           dmem_req_in, dmem_ack_in,
    input  pc_en_out, rb1_en_out, rb1_flush_out, rb2_en_out, rb2_flush_out,
           bus_err_out, state_out, stall_cnt_out, flush_cnt_out
  );
endinterface

// File: rtl/msrv32_pipe_ctrl.sv
// Three-stage pipeline controller: post-reset flush, redirect/load-use/memory-wait handling, timeout.
// Enables/flushes are combinational from state and inputs; a memory wait freezes the whole pipe.
module msrv32_pipe_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk_in,
  input  logic                reset_in,
  msrv32_pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [3:0]       r_init_cnt;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_mem_wait, w_redirect, w_hazard, w_timeout;
  logic w_pc_en, w_rb1_en, w_rb1_flush, w_rb2_en, w_rb2_flush, w_bus_err;
  logic w_flush_evt, w_stall_evt;

  assign w_mem_wait = bus.dmem_req_in & ~bus.dmem_ack_in;
  assign w_redirect = bus.branch_taken_in | bus.trap_taken_in;
  assign w_hazard   = bus.ex_load_in && (bus.ex_rd_addr_in != 5'd0) &&
                      ((bus.id_rs1_used_in && (bus.id_rs1_addr_in == bus.ex_rd_addr_in)) ||
                       (bus.id_rs2_used_in && (bus.id_rs2_addr_in == bus.ex_rd_addr_in)));
  assign w_timeout  = (r_wait_cnt == WAIT_LAST);

  always_comb begin
    w_pc_en     = 1'b0;
    w_rb1_en    = 1'b0;
    w_rb1_flush = 1'b0;
    w_rb2_en    = 1'b0;
    w_rb2_flush = 1'b0;
    w_bus_err   = 1'b0;
    w_flush_evt = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_rb1_en    = 1'b1;
        w_rb1_flush = 1'b1;
        w_rb2_en    = 1'b1;
        w_rb2_flush = 1'b1;
      end
      ST_RUN: begin
        // Memory wait outranks a redirect: the frozen branch is re-presented afterwards.
        if (w_mem_wait) begin
          w_pc_en = 1'b0;
        end else if (w_redirect) begin
          w_pc_en     = 1'b1;
          w_rb1_en    = 1'b1;
          w_rb1_flush = 1'b1;
          w_rb2_en    = 1'b1;
          w_rb2_flush = 1'b1;
          w_flush_evt = 1'b1;
        end else if (w_hazard) begin
          w_rb2_en    = 1'b1;
          w_rb2_flush = 1'b1;
        end else begin
          w_pc_en  = 1'b1;
          w_rb1_en = 1'b1;
          w_rb2_en = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ack_in) begin
          w_pc_en  = 1'b1;
          w_rb1_en = 1'b1;
          w_rb2_en = 1'b1;
        end else if (w_timeout) begin
          w_bus_err   = 1'b1;
          w_rb2_en    = 1'b1;
          w_rb2_flush = 1'b1;
        end
      end
      default: begin
        w_pc_en = 1'b0;
      end
    endcase
  end

  assign w_stall_evt = (r_state != ST_INIT) && !w_pc_en;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= 4'd0;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == INIT_LAST) r_state <= ST_RUN;
          else                         r_init_cnt <= r_init_cnt + 4'd1;
        end
        ST_RUN: begin
          if (w_mem_wait) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.dmem_ack_in || w_timeout) r_state <= ST_RUN;
          else                              r_wait_cnt <= r_wait_cnt + 8'd1;
        end
        default: r_state <= ST_INIT;
      endcase
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_en_out     = w_pc_en;
  assign bus.rb1_en_out    = w_rb1_en;
  assign bus.rb1_flush_out = w_rb1_flush;
  assign bus.rb2_en_out    = w_rb2_en;
  assign bus.rb2_flush_out = w_rb2_flush;
  assign bus.bus_err_out   = w_bus_err;
  assign bus.state_out     = r_state;
  assign bus.stall_cnt_out = r_stall_cnt;
  assign bus.flush_cnt_out = r_flush_cnt;

endmodule

// File: tb/tb_msrv32_pipe_ctrl.sv
// Bench for msrv32_pipe_ctrl: directed scenarios plus randomized traffic against a rule-table model.
// Small counters (4 bits) and a short memory timeout make saturation and timeouts easy to reach.
module tb_msrv32_pipe_ctrl;
  localparam int IC    = 2;
  localparam int TO    = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msrv32_pipe_ctrl_if #(.CNT_W(CW)) bus ();

  msrv32_pipe_ctrl #(.INIT_CYCLES(IC), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0=INIT,1=RUN,2=MEM_WAIT; cycles spent in the current phase; event counters.
  int m_ph, m_ticks, m_stall, m_flush;
  bit m_known = 1'b0;
  int n_ph, n_ticks, n_stall, n_flush;
  bit n_known;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit br, input bit tr, input bit ld, input int rd,
                       input int rs1, input bit u1, input int rs2, input bit u2,
                       input bit req, input bit ack);
    rst                 = r;
    bus.branch_taken_in = br;
    bus.trap_taken_in   = tr;
    bus.ex_load_in      = ld;
    bus.ex_rd_addr_in   = 5'(rd);
    bus.id_rs1_addr_in  = 5'(rs1);
    bus.id_rs1_used_in  = u1;
    bus.id_rs2_addr_in  = 5'(rs2);
    bus.id_rs2_used_in  = u2;
    bus.dmem_req_in     = req;
    bus.dmem_ack_in     = ack;
  endtask

  // Applies the current inputs, then at the falling edge compares the DUT with the rule table.
  task automatic step();
    bit pc, e1, f1, e2, f2, er, haz;
    logic [31:0] exp_v, act_v;
    @(negedge clk);
    {pc, e1, f1, e2, f2, er} = 6'b0;
    n_ph = m_ph; n_ticks = m_ticks + 1; n_stall = m_stall; n_flush = m_flush;
    haz = bus.ex_load_in && bus.ex_rd_addr_in != 0 &&
          ((bus.id_rs1_used_in && bus.id_rs1_addr_in == bus.ex_rd_addr_in) ||
           (bus.id_rs2_used_in && bus.id_rs2_addr_in == bus.ex_rd_addr_in));
    if (m_ph == 0) begin
      {e1, f1, e2, f2} = 4'b1111;
      if (m_ticks + 1 >= IC) begin n_ph = 1; n_ticks = 0; end
    end else if (m_ph == 1) begin
      if (bus.dmem_req_in && !bus.dmem_ack_in) begin
        n_ph = 2; n_ticks = 0;
      end else if (bus.branch_taken_in || bus.trap_taken_in) begin
        {pc, e1, f1, e2, f2} = 5'b11111;
        n_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      end else if (haz) begin
        {e2, f2} = 2'b11;
      end else begin
        {pc, e1, e2} = 3'b111;
      end
    end else begin
      if (bus.dmem_ack_in) begin
        {pc, e1, e2} = 3'b111; n_ph = 1; n_ticks = 0;
      end else if (m_ticks + 1 >= TO) begin
        {er, e2, f2} = 3'b111; n_ph = 1; n_ticks = 0;
      end
    end
    if (m_ph != 0 && !pc) n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    n_known = m_known;
    if (rst) begin
      n_ph = 0; n_ticks = 0; n_stall = 0; n_flush = 0; n_known = 1'b1;
    end
    if (m_known) begin
      exp_v = {14'd0, pc, e1, f1, e2, f2, er, 2'(m_ph), 4'(m_stall), 4'(m_flush)};
      act_v = {14'd0, bus.pc_en_out, bus.rb1_en_out, bus.rb1_flush_out, bus.rb2_en_out,
               bus.rb2_flush_out, bus.bus_err_out, bus.state_out, bus.stall_cnt_out,
               bus.flush_cnt_out};
      chk("model", act_v, exp_v);
    end
  endtask

  task automatic tick();
    m_ph = n_ph; m_ticks = n_ticks; m_stall = n_stall; m_flush = n_flush; m_known = n_known;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset held for three edges, then two INIT cycles before RUN.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 1, 3, 3, 1, 3, 1, 1, 0);
      step();
      tick();
    end
    for (int i = 0; i < IC; i++) begin
      idle(); step();
      chk("init_pc_en", bus.pc_en_out, 0);
      chk("init_flush", {bus.rb1_flush_out, bus.rb2_flush_out}, 2'b11);
      tick();
    end
    idle(); step();
    chk("run_state", bus.state_out, 1);
    chk("run_enables", {bus.pc_en_out, bus.rb1_en_out, bus.rb2_en_out}, 3'b111);
    chk("run_cnts", {bus.stall_cnt_out, bus.flush_cnt_out}, 0);
    tick();

    // Load-use hazard, then the same with rd=x0.
    drive(0, 0, 0, 1, 5, 5, 1, 0, 0, 0, 0); step();
    chk("lu_stall", {bus.pc_en_out, bus.rb1_en_out, bus.rb2_flush_out}, 3'b001);
    tick();
    drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0); step();
    chk("lu_x0_nostall", bus.pc_en_out, 1);
    chk("lu_stall_cnt", bus.stall_cnt_out, 1);
    tick();

    // Redirect beats the hazard.
    drive(0, 1, 0, 1, 5, 5, 1, 0, 0, 0, 0); step();
    chk("br_over_lu", {bus.pc_en_out, bus.rb1_flush_out, bus.rb2_flush_out}, 3'b111);
    tick();
    idle(); step();
    chk("br_cnts", {bus.stall_cnt_out, bus.flush_cnt_out}, {4'd1, 4'd1});
    tick();

    // Memory wait acknowledged on the fourth cycle.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
      chk("mw_frozen", {bus.pc_en_out, bus.rb1_en_out, bus.rb2_en_out, bus.bus_err_out}, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    chk("mw_ack", {bus.pc_en_out, bus.rb1_en_out, bus.rb2_en_out, bus.bus_err_out}, 4'b1110);
    tick();
    idle(); step();
    chk("mw_after", {bus.state_out, bus.stall_cnt_out}, {2'd1, 4'd4});
    tick();

    // Memory timeout with ack never arriving.
    for (int i = 0; i <= TO; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
      chk("to_err", {bus.bus_err_out, bus.rb2_flush_out}, (i == TO) ? 2'b11 : 2'b00);
      tick();
    end
    idle(); step();
    chk("to_after", {bus.state_out, bus.stall_cnt_out}, {2'd1, 4'd9});
    tick();

    // Saturate stall_cnt, then reset from inside MEM_WAIT.
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 1, 7, 0, 0, 7, 1, 0, 0); step(); tick();
    end
    idle(); step();
    chk("stall_sat", bus.stall_cnt_out, CMAX);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step(); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
    chk("rst_in_mw_state", bus.state_out, 2);
    tick();
    idle(); step();
    chk("rst_mw_after", {bus.state_out, bus.stall_cnt_out, bus.flush_cnt_out}, 0);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      step();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
